// File: rtl/clkdiv_n.sv
// Programmable integer clock divider.
// Produces a glitch-free divided clock of period N with 50% duty, where odd N
// gets its extra half cycle from a falling-edge copy of the high-phase flop.
// A shadow divisor register lets N change on the fly. The new value only takes
// effect at a period boundary, so no runt or stretched pulse is produced.
// A run enable finishes the current period before parking the output low.
module clkdiv_n #(
    parameter int CNT_W    = 8,
    parameter int DIV_INIT = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    // Reset divisor. Values below 2 would give no meaningful period, so they
    // are raised to 2.
    localparam logic [CNT_W-1:0] DIV_RST = (DIV_INIT < 2) ? CNT_W'(2) : CNT_W'(DIV_INIT);

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(2)) ? CNT_W'(2) : d;
    endfunction

    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [CNT_W-1:0] active_reg, active_next;
    logic [CNT_W-1:0] shadow_reg, shadow_next;
    logic             busy_reg,   busy_next;
    logic             run_reg,    run_next;
    logic             p_reg,      p_next;
    logic             tick_reg,   tick_next;
    logic             n_reg;
    logic             wrap;
    logic [CNT_W-1:0] half;

    // Next-state logic: advance the period counter, handle period boundaries
    // (wrap or start from park), apply pending divisors and capture new loads.
    always_comb begin
        cnt_next    = cnt_reg;
        active_next = active_reg;
        shadow_next = shadow_reg;
        busy_next   = busy_reg;
        run_next    = run_reg;
        wrap        = run_reg && (cnt_reg == (active_reg - CNT_W'(1)));

        if (!run_reg || wrap) begin
            // A boundary: either a new period starts or the block parks.
            cnt_next = '0;
            run_next = en;
            // A load in the boundary cycle itself defers to the next boundary,
            // so only a shadow value captured earlier is applied here. While
            // parked, a pending value waits until the block restarts.
            if (en && busy_reg && !load) begin
                active_next = shadow_reg;
                busy_next   = 1'b0;
            end
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        if (load) begin
            shadow_next = clamp_div(div);
            busy_next   = 1'b1;
        end

        // High phase covers cnt 0..floor(N/2)-1. For odd N the falling-edge
        // flop adds the missing half cycle.
        half      = active_next >> 1;
        p_next    = run_next && (cnt_next < half);
        tick_next = run_next && (cnt_next == '0);
    end

    // Rising-edge state, cleared asynchronously by rst_.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            cnt_reg    <= '0;
            active_reg <= DIV_RST;
            shadow_reg <= DIV_RST;
            busy_reg   <= 1'b0;
            run_reg    <= 1'b0;
            p_reg      <= 1'b0;
            tick_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            active_reg <= active_next;
            shadow_reg <= shadow_next;
            busy_reg   <= busy_next;
            run_reg    <= run_next;
            p_reg      <= p_next;
            tick_reg   <= tick_next;
        end
    end

    // Half-cycle extension for odd divisors. It is held low for even N so
    // the duty stays exactly N/2.
    always_ff @(negedge clk or posedge rst_) begin
        if (rst_) begin
            n_reg <= 1'b0;
        end else begin
            n_reg <= p_reg & active_reg[0];
        end
    end

    // Output is built only from flop outputs through one OR gate.
    assign clk_out = p_reg | n_reg;
    assign tick    = tick_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_clkdiv_n.sv
// Self-checking bench for clkdiv_n. A behavioural model tracks the position
// inside the current period and the divisor in force. The expected clk_out for
// each half cycle is derived as "half-cycle index < N".
module tb_clkdiv_n;

    logic       clk;
    logic       rst_;
    logic       en;
    logic [7:0] div;
    logic       load;
    logic       clk_out;
    logic       tick;
    logic       busy;

    clkdiv_n #(.CNT_W(8), .DIV_INIT(4)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .en      (en),
        .div     (div),
        .load    (load),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state
    bit m_run;
    int m_pos;
    int m_per;
    int m_shadow;
    bit m_busy;

    logic exp_a, exp_b, exp_t, exp_busy;
    logic obs_a, obs_b, obs_t, obs_busy;

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_per = 4; m_shadow = 4; m_busy = 0;
        exp_a = 0; exp_b = 0; exp_t = 0; exp_busy = 0;
    endtask

    task automatic model_edge(input bit e, input bit l, input int d);
        bit boundary;
        boundary = !m_run || (m_pos == m_per - 1);
        if (boundary) begin
            if (e) begin
                if (m_busy && !l) begin
                    m_per  = m_shadow;
                    m_busy = 0;
                end
                m_run = 1;
            end else begin
                m_run = 0;
            end
            m_pos = 0;
        end else begin
            m_pos++;
        end
        if (l) begin
            m_shadow = clampd(d);
            m_busy   = 1;
        end
        exp_a    = m_run && (2 * m_pos < m_per);
        exp_b    = m_run && (2 * m_pos + 1 < m_per);
        exp_t    = m_run && (m_pos == 0);
        exp_busy = m_busy;
    endtask

    // One clk cycle: drive inputs, update the model on the edge, sample both halves.
    task automatic step(input bit e, input bit l, input int d);
        en = e; load = l; div = 8'(d);
        @(posedge clk);
        model_edge(e, l, d);
        cyc++;
        #1;
        obs_a = clk_out; obs_t = tick; obs_busy = busy;
        @(negedge clk);
        #1;
        obs_b = clk_out;
    endtask

    task automatic test_reset();
        rst_ = 1'b1; en = 1'b0; load = 1'b0; div = 8'd0;
        model_reset();
        #12;
        n_checks++;
        if ({clk_out, tick, busy} !== 3'b000)
            $display("FAIL reset_outputs got clk_out/tick/busy=%b%b%b want 000", clk_out, tick, busy);
        else n_pass++;
        @(negedge clk);
        rst_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            n_checks++;
            if ({obs_a, obs_b, obs_t, obs_busy} !== {exp_a, exp_b, exp_t, exp_busy})
                $display("FAIL reset_idle cyc=%0d got a/b/tick/busy=%b%b%b%b want %b%b%b%b",
                         cyc, obs_a, obs_b, obs_t, obs_busy, exp_a, exp_b, exp_t, exp_busy);
            else n_pass++;
        end
    endtask

    task automatic test_div4();
        int ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0);
            if (obs_t) ticks++;
            n_checks++;
            if ({obs_a, obs_b} !== {exp_a, exp_b})
                $display("FAIL div4_clk_out cyc=%0d got %b%b want %b%b", cyc, obs_a, obs_b, exp_a, exp_b);
            else n_pass++;
            n_checks++;
            if (obs_t !== exp_t || (obs_t && !obs_a))
                $display("FAIL div4_tick cyc=%0d got %b want %b (clk_out %b)", cyc, obs_t, exp_t, obs_a);
            else n_pass++;
        end
        n_checks++;
        if (ticks != 3) $display("FAIL div4_tick_count got %0d want 3", ticks);
        else n_pass++;
    endtask

    task automatic test_load3();
        for (int i = 0; i < 8 && m_pos != 1; i++) step(1, 0, 0);
        step(1, 1, 3);
        n_checks++;
        if (obs_busy !== 1'b1) $display("FAIL load3_busy_set got %b want 1", obs_busy);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0);
            n_checks++;
            if ({obs_a, obs_b, obs_t} !== {exp_a, exp_b, exp_t})
                $display("FAIL load3_wave cyc=%0d got a/b/tick=%b%b%b want %b%b%b",
                         cyc, obs_a, obs_b, obs_t, exp_a, exp_b, exp_t);
            else n_pass++;
            n_checks++;
            if (obs_busy !== exp_busy)
                $display("FAIL load3_busy cyc=%0d got %b want %b", cyc, obs_busy, exp_busy);
            else n_pass++;
        end
    endtask

    task automatic test_clamp();
        int last_tick = -1;
        int bad_gap   = 0;
        step(1, 1, 0);
        for (int i = 0; i < 20 && (m_busy || m_pos != 0); i++) step(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            if (obs_t) begin
                if (last_tick >= 0 && cyc - last_tick != 2) bad_gap++;
                last_tick = cyc;
            end
            n_checks++;
            if ({obs_a, obs_b, obs_t, obs_busy} !== {exp_a, exp_b, exp_t, exp_busy})
                $display("FAIL clamp_n2 cyc=%0d got a/b/tick/busy=%b%b%b%b want %b%b%b%b",
                         cyc, obs_a, obs_b, obs_t, obs_busy, exp_a, exp_b, exp_t, exp_busy);
            else n_pass++;
        end
        n_checks++;
        if (bad_gap != 0 || last_tick < 0) $display("FAIL clamp_tick_gap got %0d bad gaps want 0", bad_gap);
        else n_pass++;
        step(1, 1, 255);
        for (int i = 0; i < 600; i++) begin
            step(1, 0, 0);
            n_checks++;
            if ({obs_a, obs_b, obs_t, obs_busy} !== {exp_a, exp_b, exp_t, exp_busy})
                $display("FAIL clamp_n255 cyc=%0d got a/b/tick/busy=%b%b%b%b want %b%b%b%b",
                         cyc, obs_a, obs_b, obs_t, obs_busy, exp_a, exp_b, exp_t, exp_busy);
            else n_pass++;
        end
    endtask

    task automatic test_enable();
        int parked_ticks = 0;
        step(1, 1, 6);
        for (int i = 0; i < 600 && (m_busy || m_pos != 1); i++) step(1, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 0);
            if (i >= 5 && (obs_t || obs_a || obs_b)) parked_ticks++;
            n_checks++;
            if ({obs_a, obs_b, obs_t} !== {exp_a, exp_b, exp_t})
                $display("FAIL enable_drop cyc=%0d got a/b/tick=%b%b%b want %b%b%b",
                         cyc, obs_a, obs_b, obs_t, exp_a, exp_b, exp_t);
            else n_pass++;
        end
        n_checks++;
        if (parked_ticks != 0) $display("FAIL enable_parked got %0d active cycles want 0", parked_ticks);
        else n_pass++;
        step(1, 0, 0);
        n_checks++;
        if ({obs_a, obs_t} !== 2'b11) $display("FAIL enable_restart got clk_out/tick=%b%b want 11", obs_a, obs_t);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            n_checks++;
            if ({obs_a, obs_b, obs_t} !== {exp_a, exp_b, exp_t})
                $display("FAIL enable_run cyc=%0d got a/b/tick=%b%b%b want %b%b%b",
                         cyc, obs_a, obs_b, obs_t, exp_a, exp_b, exp_t);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int tq[$];
        for (int i = 0; i < 12 && m_pos != 1; i++) step(1, 0, 0);
        step(1, 1, 5);
        for (int i = 0; i < 12 && m_pos != m_per - 1; i++) step(1, 0, 0);
        step(1, 1, 7);
        if (obs_t) tq.push_back(cyc);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0);
            if (obs_t) tq.push_back(cyc);
            n_checks++;
            if ({obs_a, obs_b, obs_t, obs_busy} !== {exp_a, exp_b, exp_t, exp_busy})
                $display("FAIL b2b_wave cyc=%0d got a/b/tick/busy=%b%b%b%b want %b%b%b%b",
                         cyc, obs_a, obs_b, obs_t, obs_busy, exp_a, exp_b, exp_t, exp_busy);
            else n_pass++;
        end
        n_checks++;
        if (tq.size() < 3) $display("FAIL b2b_ticks got %0d ticks want >=3", tq.size());
        else if (tq[1] - tq[0] != 6 || tq[2] - tq[1] != 7)
            $display("FAIL b2b_periods got %0d,%0d want 6,7", tq[1] - tq[0], tq[2] - tq[1]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int tq[$];
        step(1, 1, 5);
        for (int i = 0; i < 40 && (m_busy || m_pos != 4); i++) step(1, 0, 0);
        step(1, 1, 9);
        n_checks++;
        if ({obs_b, obs_t, obs_busy} !== 3'b111)
            $display("FAIL areset_pre got clk_out/tick/busy=%b%b%b want 111", obs_b, obs_t, obs_busy);
        else n_pass++;
        rst_ = 1'b1;
        #1;
        n_checks++;
        if ({clk_out, tick, busy} !== 3'b000)
            $display("FAIL areset_drop got clk_out/tick/busy=%b%b%b want 000", clk_out, tick, busy);
        else n_pass++;
        #2;
        rst_ = 1'b0;
        model_reset();
        for (int i = 0; i < 13; i++) begin
            step(1, 0, 0);
            if (obs_t) tq.push_back(cyc);
            n_checks++;
            if ({obs_a, obs_b, obs_t, obs_busy} !== {exp_a, exp_b, exp_t, exp_busy})
                $display("FAIL areset_after cyc=%0d got a/b/tick/busy=%b%b%b%b want %b%b%b%b",
                         cyc, obs_a, obs_b, obs_t, obs_busy, exp_a, exp_b, exp_t, exp_busy);
            else n_pass++;
        end
        n_checks++;
        if (tq.size() < 2 || tq[1] - tq[0] != 4)
            $display("FAIL areset_divinit got %0d ticks / gap %0d want gap 4",
                     tq.size(), (tq.size() >= 2) ? tq[1] - tq[0] : -1);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit e, l;
            int d;
            e = ($urandom_range(0, 99) < 85);
            l = ($urandom_range(0, 7) == 0);
            d = $urandom_range(0, 9);
            step(e, l, d);
            n_checks++;
            if ({obs_a, obs_b, obs_t, obs_busy} !== {exp_a, exp_b, exp_t, exp_busy})
                $display("FAIL random cyc=%0d got a/b/tick/busy=%b%b%b%b want %b%b%b%b",
                         cyc, obs_a, obs_b, obs_t, obs_busy, exp_a, exp_b, exp_t, exp_busy);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_load3();
        test_clamp();
        test_enable();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Upper bound on run time so the bench always ends.
    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clkdiv_n.md
CLKDIV_N -- requirements
Module: clkdiv_n

Interface
REQ-001 Parameter CNT_W, default 8: width of the divisor and of the internal period counter.
REQ-002 Parameter DIV_INIT, default 4: divisor in force after reset; legal range 2..2^CNT_W-1.
REQ-003 Port clk, input, 1: sole clock; all state is clocked on rising clk, except the single half-cycle flop in REQ-014.
REQ-004 Port rst_, input, 1: reset, asynchronous assert, active-high (rst_=1 resets).
REQ-005 Port en, input, 1: run enable, sampled on rising clk.
REQ-006 Port div, input, CNT_W: requested divisor N, unsigned.
REQ-007 Port load, input, 1: single-cycle strobe; captures div into the shadow register.
REQ-008 Port clk_out, output, 1: divided clock, period N clk cycles, 50% duty.
REQ-009 Port tick, output, 1: one-clk-cycle pulse marking the start of each clk_out period.
REQ-010 Port busy, output, 1: high while a loaded divisor is pending and not yet applied.

Function
REQ-011 Internal period counter cnt counts 0..N-1 and wraps to 0; N is the active divisor.
REQ-012 Any div value below 2 (0 or 1), whether captured or given as DIV_INIT, is clamped to 2; no bypass mode exists.
REQ-013 Even N: clk_out is high for cnt 0..N/2-1 and low for cnt N/2..N-1, so the high and low phases are exactly N/2 cycles each.
REQ-014 Odd N: clk_out = p OR n.
- p: registered, high for cnt 0..(N-1)/2-1.
- n: p re-registered on falling clk.
- Result: high phase of N/2 clk cycles (e.g. N=3 gives 1.5 high, 1.5 low).
REQ-015 For even N, n is held at 0.
REQ-016 clk_out is driven only from flop outputs through the single OR gate; it never glitches.
REQ-017 tick is asserted in the clk cycle in which cnt=0 and the block is running, so it is coincident with the rising edge of clk_out.
REQ-018 load=1 copies div into the shadow register and sets busy on the next rising clk.
REQ-019 The shadow divisor becomes active only at the wrap from cnt=N-1 to 0.
- busy clears on that same edge.
- The new period starts with the new N.
- No runt or stretched pulse is produced.
REQ-020 If load is asserted again while busy=1, the latest div overwrites the shadow; only the last value is applied.
REQ-021 If load and a wrap occur in the same cycle, the new value applies at the following wrap, not the current one.
REQ-022 en deasserted mid-period: the current period completes, then the block parks.
- Parked state: cnt=0, clk_out=0, tick=0.
- Pending loads are still accepted while parked.
REQ-023 en reasserted while parked: the next rising clk starts a period at cnt=0; clk_out rises and tick pulses on that edge.
REQ-024 A pending shadow divisor is applied on leaving park, before the first new period.

Reset
REQ-025 While rst_=1, asynchronously and immediately:
- cnt=0, p=0, n=0, so clk_out=0;
- tick=0, busy=0;
- active and shadow divisors = DIV_INIT (clamped).
REQ-026 The first rising clk with rst_=0 and en=1 starts the first period at cnt=0.
REQ-027 Reset asserted mid-period truncates the period without waiting for a wrap; clk_out falls immediately, with no glitch back high.

Verification
REQ-028 Reset, then en=1 with DIV_INIT=4 -> clk_out is 2 high / 2 low clk cycles, tick every 4 cycles, tick aligned with each clk_out rise.
REQ-029 load with div=3 while running N=4 -> current 4-cycle period completes; then clk_out is high 1.5 / low 1.5 cycles, busy high for exactly the cycles between load and wrap.
REQ-030 div=0 loaded, then div=255 -> behaves as N=2 (1/1); after a later load of 255, high 127.5 and low 127.5 cycles, counter wraps at 254.
REQ-031 en dropped at cnt=1 of N=6 -> clk_out finishes the 6-cycle period then stays 0, tick silent; en raised -> clk_out rises on the next edge together with tick.
REQ-032 Two loads (5 then 7) inside one period, the second on the wrap cycle -> next period uses the old N, the period after uses 7; 5 is never seen.
REQ-033 rst_ pulsed for 3 ns mid high phase of N=5 -> clk_out, tick and busy drop to 0 at once; after release, the divisor is DIV_INIT.
